// File: rtl/rv_decode_stage.sv
// RV32I decode stage: combinational decode of the incoming word into a DEPTH-entry output FIFO.
// Optional M-extension decode is enabled by defining RV_DECODE_M_EXT_EN.
module rv_decode_stage #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned PC_W  = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_inst,
    input  logic [PC_W-1:0]            in_pc,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [20:0]                out_ctrl,
    output logic [2:0]                 out_muldiv_op,
    output logic [4:0]                 out_rs1,
    output logic [4:0]                 out_rs2,
    output logic [4:0]                 out_rd,
    output logic [31:0]                out_imm,
    output logic [PC_W-1:0]            out_pc,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [2:0] IMM_NONE = 3'b000;
    localparam logic [2:0] IMM_I    = 3'b001;
    localparam logic [2:0] IMM_U    = 3'b010;
    localparam logic [2:0] IMM_S    = 3'b011;
    localparam logic [2:0] IMM_B    = 3'b100;
    localparam logic [2:0] IMM_J    = 3'b101;

    // alu_src = {op2[1:0], op1}; op2: 00 rs2, 01 imm, 10 constant 4; op1: 0 rs1, 1 pc
    localparam logic [2:0] SRC_RR    = 3'b000;
    localparam logic [2:0] SRC_RS1_I = 3'b010;
    localparam logic [2:0] SRC_PC_I  = 3'b011;
    localparam logic [2:0] SRC_PC_4  = 3'b101;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_PASS = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1010;

    typedef struct packed {
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic [2:0] mem_op;
        logic [3:0] alu_op;
        logic [2:0] alu_src;
        logic [2:0] imm_op;
        logic [2:0] branch;
        logic       illegal;
        logic       is_muldiv;
    } ctrl_t;

    typedef struct packed {
        ctrl_t           ctrl;
        logic [2:0]      muldiv_op;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [31:0]     imm;
        logic [PC_W-1:0] pc;
    } entry_t;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        f7_ok;
    logic        illegal_c;
    logic [3:0]  alu_rr_c;
    ctrl_t       ctrl_c;
    logic [2:0]  muldiv_op_c;
    logic [31:0] imm_c;
    entry_t      entry_c;

    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push, pop;
    entry_t           head;

    assign opcode   = in_inst[6:0];
    assign funct3   = in_inst[14:12];
    assign funct7   = in_inst[31:25];
    assign f7_ok    = (funct7 == F7_BASE) || (funct7 == F7_ALT);
    // sltu is remapped so that 0011 is free for the lui pass-through op
    assign alu_rr_c = (funct3 == 3'b011) ? ALU_SLTU : {funct7[5], funct3};

    always_comb begin : decode
        ctrl_c      = '0;
        muldiv_op_c = 3'b000;
        illegal_c   = 1'b0;
        case (opcode)
            OP_R: begin
                if (funct7 == F7_MULDIV) begin
`ifdef RV_DECODE_M_EXT_EN
                    ctrl_c.is_muldiv = 1'b1;
                    ctrl_c.reg_write = 1'b1;
                    muldiv_op_c      = funct3;
`else
                    illegal_c = 1'b1;
`endif
                end else if (f7_ok) begin
                    ctrl_c.reg_write = 1'b1;
                    ctrl_c.alu_op    = alu_rr_c;
                end else begin
                    illegal_c = 1'b1;
                end
            end
            OP_IMM: begin
                ctrl_c.reg_write = 1'b1;
                ctrl_c.alu_src   = SRC_RS1_I;
                ctrl_c.imm_op    = IMM_I;
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    ctrl_c.alu_op = {funct7[5], funct3};
                    illegal_c     = !f7_ok;
                end else begin
                    ctrl_c.alu_op = (funct3 == 3'b011) ? ALU_SLTU : {1'b0, funct3};
                end
            end
            OP_LOAD: begin
                ctrl_c.reg_write  = 1'b1;
                ctrl_c.mem_to_reg = 1'b1;
                ctrl_c.alu_src    = SRC_RS1_I;
                ctrl_c.imm_op     = IMM_I;
                case (funct3)
                    3'b000:  ctrl_c.mem_op = 3'b001;
                    3'b001:  ctrl_c.mem_op = 3'b010;
                    3'b010:  ctrl_c.mem_op = 3'b011;
                    3'b100:  ctrl_c.mem_op = 3'b101;
                    3'b101:  ctrl_c.mem_op = 3'b110;
                    default: illegal_c = 1'b1;
                endcase
            end
            OP_STORE: begin
                ctrl_c.mem_write = 1'b1;
                ctrl_c.alu_src   = SRC_RS1_I;
                ctrl_c.imm_op    = IMM_S;
                case (funct3)
                    3'b000:  ctrl_c.mem_op = 3'b001;
                    3'b001:  ctrl_c.mem_op = 3'b010;
                    3'b010:  ctrl_c.mem_op = 3'b011;
                    default: illegal_c = 1'b1;
                endcase
            end
            OP_BRANCH: begin
                ctrl_c.imm_op = IMM_B;
                ctrl_c.alu_src = SRC_RR;
                // alu_op carries the compare flavour since blt/bltu share a branch code
                case (funct3)
                    3'b000:  begin ctrl_c.branch = 3'b100; ctrl_c.alu_op = ALU_SUB;  end
                    3'b001:  begin ctrl_c.branch = 3'b101; ctrl_c.alu_op = ALU_SUB;  end
                    3'b100:  begin ctrl_c.branch = 3'b110; ctrl_c.alu_op = ALU_SLT;  end
                    3'b101:  begin ctrl_c.branch = 3'b111; ctrl_c.alu_op = ALU_SLT;  end
                    3'b110:  begin ctrl_c.branch = 3'b110; ctrl_c.alu_op = ALU_SLTU; end
                    3'b111:  begin ctrl_c.branch = 3'b111; ctrl_c.alu_op = ALU_SLTU; end
                    default: illegal_c = 1'b1;
                endcase
            end
            OP_JAL: begin
                ctrl_c.reg_write = 1'b1;
                ctrl_c.alu_src   = SRC_PC_4;
                ctrl_c.imm_op    = IMM_J;
                ctrl_c.branch    = 3'b001;
            end
            OP_JALR: begin
                ctrl_c.reg_write = 1'b1;
                ctrl_c.alu_src   = SRC_PC_4;
                ctrl_c.imm_op    = IMM_I;
                ctrl_c.branch    = 3'b010;
                illegal_c        = (funct3 != 3'b000);
            end
            OP_LUI: begin
                ctrl_c.reg_write = 1'b1;
                ctrl_c.alu_src   = SRC_RS1_I;
                ctrl_c.imm_op    = IMM_U;
                ctrl_c.alu_op    = ALU_PASS;
            end
            OP_AUIPC: begin
                ctrl_c.reg_write = 1'b1;
                ctrl_c.alu_src   = SRC_PC_I;
                ctrl_c.imm_op    = IMM_U;
                ctrl_c.alu_op    = ALU_ADD;
            end
            default: illegal_c = 1'b1;
        endcase
        if (illegal_c) begin
            ctrl_c         = '0;
            ctrl_c.illegal = 1'b1;
            muldiv_op_c    = 3'b000;
        end
    end

    always_comb begin : imm_gen
        imm_c = 32'h0;
        case (ctrl_c.imm_op)
            IMM_I:   imm_c = {{20{in_inst[31]}}, in_inst[31:20]};
            IMM_U:   imm_c = {in_inst[31:12], 12'h000};
            IMM_S:   imm_c = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            IMM_B:   imm_c = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                              in_inst[11:8], 1'b0};
            IMM_J:   imm_c = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                              in_inst[30:21], 1'b0};
            IMM_NONE: imm_c = 32'h0;
            default: imm_c = 32'h0;
        endcase
    end

    always_comb begin : entry_pack
        entry_c           = '0;
        entry_c.ctrl      = ctrl_c;
        entry_c.muldiv_op = muldiv_op_c;
        entry_c.rs1       = in_inst[19:15];
        entry_c.rs2       = in_inst[24:20];
        entry_c.rd        = in_inst[11:7];
        entry_c.imm       = imm_c;
        entry_c.pc        = in_pc;
    end

    assign out_valid = (count_q != '0);
    assign in_ready  = (count_q != CNT_W'(DEPTH));
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // flush wins over any same-cycle push or pop
    always_comb begin : fifo_next
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                mem_d[wptr_q] = entry_c;
                wptr_d        = wptr_q + PTR_W'(1);
            end
            if (pop) begin
                rptr_d = rptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end

    // head fields are gated so an empty buffer presents all zeros
    assign head          = mem_q[rptr_q];
    assign out_ctrl      = out_valid ? head.ctrl      : '0;
    assign out_muldiv_op = out_valid ? head.muldiv_op : 3'b000;
    assign out_rs1       = out_valid ? head.rs1       : 5'd0;
    assign out_rs2       = out_valid ? head.rs2       : 5'd0;
    assign out_rd        = out_valid ? head.rd        : 5'd0;
    assign out_imm       = out_valid ? head.imm       : 32'h0;
    assign out_pc        = out_valid ? head.pc        : '0;
    assign count         = count_q;

endmodule

// File: doc/rv_decode_stage.md
RV_DECODE_STAGE -- requirements
Module: rv_decode_stage

Interface
REQ-001 Parameter DEPTH, default 2: output buffer entries; power of two, at least 2.
REQ-002 Parameter PC_W, default 32: width of the PC carried alongside the instruction.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 in_valid  input  1  upstream has an instruction.
REQ-006 in_ready  output  1  stage can accept; equals buffer not full.
REQ-007 in_inst  input  32  instruction word.
REQ-008 in_pc  input  PC_W  PC of in_inst.
REQ-009 flush  input  1  synchronous discard of all buffered entries.
REQ-010 out_valid  output  1  head entry valid; equals buffer not empty.
REQ-011 out_ready  input  1  downstream accepts the head entry.
REQ-012 out_ctrl  output  21  head entry control fields: {mem_write, mem_to_reg, reg_write, mem_op[2:0], alu_op[3:0], alu_src[2:0], imm_op[2:0], branch[2:0], illegal, is_muldiv}.
REQ-013 out_muldiv_op  output  3  funct3 of an M-extension instruction; 0 otherwise.
REQ-014 out_rs1, out_rs2, out_rd  output  5 each  register indices (inst[19:15], [24:20], [11:7]).
REQ-015 out_imm  output  32  sign-extended immediate selected by imm_op (I=001, U=010, S=011, B=100, J=101, none=000 gives 0).
REQ-016 out_pc  output  PC_W  PC of the head entry.
REQ-017 count  output  log2(DEPTH)+1  number of occupied entries.

Function
REQ-018 Decode SHALL be combinational on in_inst and use the team RV32I encodings: R alu_op {funct7[5],funct3} except sltu=1010; load/store mem_op lb/sb=001, lh/sh=010, lw/sw=011, lbu=101, lhu=110; branch beq=100, bne=101, blt/bltu=110, bge/bgeu=111, jal=001, jalr=010; alu_src {op2[1:0],op1}.
REQ-019 Loads SHALL assert reg_write=1 together with mem_to_reg=1.
REQ-020 Illegal SHALL be asserted for: inst[1:0]!=11, an unlisted opcode, an undefined funct3, or funct7 other than 0000000/0100000 where funct7 is checked; when illegal=1, mem_write, reg_write and mem_to_reg SHALL be 0 and branch SHALL be 000.
REQ-021 Push occurs when in_valid&&in_ready; pop occurs when out_valid&&out_ready; both may occur in the same cycle, leaving count unchanged.
REQ-022 Latency SHALL be one cycle: an instruction accepted at edge N appears on out_* after edge N when the buffer was empty; there is no combinational in-to-out path.
REQ-023 in_ready SHALL depend only on count, never on out_ready; when count==DEPTH, in_ready=0, even if a pop occurs in that cycle.
REQ-024 Entries SHALL leave in acceptance order; read and write pointers wrap modulo DEPTH.
REQ-025 out_* SHALL hold stable while out_valid=1 and out_ready=0.
REQ-026 flush=1 SHALL set count to 0 at the next edge, discarding any same-cycle push and ignoring any same-cycle pop.
REQ-027 When out_valid=0, out_ctrl, out_imm and out_pc SHALL read 0.

Reset
REQ-028 rst_n low SHALL immediately clear pointers and count, forcing out_valid=0, in_ready=1 and all out_* to 0, including in the middle of an operation.
REQ-029 After rst_n deasserts, the first push SHALL take effect at the first following rising edge.

Configuration
REQ-030 Macro RV_DECODE_M_EXT_EN: when defined, opcode 0110011 with funct7=0000001 decodes as legal with is_muldiv=1, reg_write=1, out_muldiv_op=funct3, alu_op=0000 and alu_src=000.
REQ-031 Without RV_DECODE_M_EXT_EN, that encoding SHALL set illegal=1, is_muldiv SHALL be tied to 0 and out_muldiv_op SHALL be tied to 0.

Verification
REQ-032 Push 0x002081B3 (add x3,x1,x2) into an empty buffer -> next cycle out_valid=1, alu_op=0000, reg_write=1, rs1=1, rs2=2, rd=3, illegal=0.
REQ-033 Push 0x00812283 (lw x5,8(x2)) -> mem_op=011, mem_to_reg=1, reg_write=1, imm_op=001, out_imm=8, rd=5.
REQ-034 DEPTH=2 with out_ready=0 and three back-to-back pushes -> in_ready=0 after the second push, count=2, third instruction held upstream; then out_ready=1 -> entries drain in order.
REQ-035 Push 0xFFFFFFFF, then 0x00000013 -> first entry has illegal=1 with reg_write=0 and mem_write=0; second entry (addi) is legal.
REQ-036 flush asserted together with a push while count=2 -> next cycle count=0, out_valid=0, in_ready=1.
REQ-037 Push 0x022081B3 (mul) -> with the macro: is_muldiv=1, out_muldiv_op=000, illegal=0; without the macro: illegal=1, reg_write=0.
